// File: rtl/stack_mc_controller_pkg.sv
// Shared definitions for the stack-machine multicycle controller:
// opcode and state encodings, push-source selects, trap codes and the
// opcode classifier used by DECODE.
package stack_mc_controller_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_NOT  = 4'h3,
    OP_PUSH = 4'h4,
    OP_POP  = 4'h5,
    OP_JMP  = 4'h6,
    OP_JZ   = 4'h7,
    OP_DUP  = 4'h8,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_LOAD_A,
    S_LOAD_B,
    S_EXEC,
    S_MEM_RD,
    S_PUSH_MDR,
    S_MEM_WR,
    S_JUMP,
    S_DUP1,
    S_DUP2,
    S_HALT,
    S_TRAP
  } state_t;

  // Instruction families as far as sequencing and stack checks care.
  typedef enum logic [2:0] {
    CLS_BIN,
    CLS_NOT,
    CLS_PUSH,
    CLS_POP,
    CLS_JUMP,
    CLS_DUP,
    CLS_HALT,
    CLS_ILLEGAL
  } op_class_t;

  localparam logic [1:0] SRC_MDR = 2'd0;
  localparam logic [1:0] SRC_ALU = 2'd1;
  localparam logic [1:0] SRC_A   = 2'd2;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_UNDER   = 2'b01;
  localparam logic [1:0] TRAP_OVER    = 2'b10;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b11;

  // Maps the low four opcode bits to an instruction family.
  function automatic op_class_t classify(input logic [3:0] op);
    op_class_t c;
    case (op)
      OP_ADD, OP_SUB, OP_AND: c = CLS_BIN;
      OP_NOT:                 c = CLS_NOT;
      OP_PUSH:                c = CLS_PUSH;
      OP_POP:                 c = CLS_POP;
      OP_JMP, OP_JZ:          c = CLS_JUMP;
      OP_DUP:                 c = CLS_DUP;
      OP_HALT:                c = CLS_HALT;
      default:                c = CLS_ILLEGAL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/stack_mc_controller_if.sv
// Control bundle between the multicycle controller (master) and the
// stack-machine datapath/memory (slave).
interface stack_mc_controller_if #(
  parameter int OPW  = 4,
  parameter int SP_W = 3
);

  logic [OPW-1:0] opcode;
  logic           tos_zero;
  logic           mem_ready;

  logic           mem_read;
  logic           mem_write;
  logic           ir_write;
  logic           pc_inc;
  logic           pc_write;
  logic           addr_src;
  logic           mdr_en;
  logic           load_a;
  logic           load_b;
  logic [1:0]     alu_op;
  logic           push;
  logic           pop;
  logic [1:0]     stack_src;
  logic [SP_W:0]  depth;
  logic           halted;
  logic           trap;
  logic [1:0]     trap_code;

  modport master (
    input  opcode, tos_zero, mem_ready,
    output mem_read, mem_write, ir_write, pc_inc, pc_write, addr_src,
           mdr_en, load_a, load_b, alu_op, push, pop, stack_src,
           depth, halted, trap, trap_code
  );

  modport slave (
    output opcode, tos_zero, mem_ready,
    input  mem_read, mem_write, ir_write, pc_inc, pc_write, addr_src,
           mdr_en, load_a, load_b, alu_op, push, pop, stack_src,
           depth, halted, trap, trap_code
  );

endinterface

// File: rtl/stack_mc_controller_depth_tracker.sv
// Stack occupancy counter. Tracks pushes/pops issued by the controller and
// exposes the full/empty/at-least-two flags DECODE uses for its traps.
module stack_depth_tracker #(
  parameter int SP_W = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  output logic [SP_W:0] depth,
  output logic          full,
  output logic          empty,
  output logic          ge2
);

  localparam logic [SP_W:0] DEPTH_V = {1'b1, {SP_W{1'b0}}};
  localparam logic [SP_W:0] ONE     = {{SP_W{1'b0}}, 1'b1};

  logic [SP_W:0] depth_q;

  // Occupancy register; push and pop are mutually exclusive by construction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      depth_q <= '0;
    end else if (push && !pop) begin
      depth_q <= depth_q + ONE;
    end else if (pop && !push) begin
      depth_q <= depth_q - ONE;
    end
  end

  assign depth = depth_q;
  assign full  = (depth_q == DEPTH_V);
  assign empty = ~|depth_q;
  assign ge2   = |depth_q[SP_W:1];

  // DECODE is responsible for never letting the counter wrap.
  property p_no_push_when_full;
    @(posedge clk) disable iff (reset) !(push && full);
  endproperty
  a_no_push_when_full: assert property (p_no_push_when_full);

  property p_no_pop_when_empty;
    @(posedge clk) disable iff (reset) !(pop && empty);
  endproperty
  a_no_pop_when_empty: assert property (p_no_pop_when_empty);

endmodule

// File: rtl/stack_mc_controller.sv
// Multicycle controller for the stack-machine datapath. Sequences
// fetch/decode/execute, stalls on memory wait states, tracks stack depth
// and traps on underflow, overflow or illegal opcodes before any stack
// strobe is issued.
module stack_mc_controller
  import stack_mc_controller_pkg::*;
#(
  parameter int OPW  = 4,
  parameter int SP_W = 3
) (
  input  logic clk,
  input  logic reset,
  stack_mc_controller_if.master bus
);

  state_t     state_q, state_d;
  logic [1:0] trap_code_q, trap_code_d;

  logic [3:0] op_lo;
  logic       upper_zero;
  op_class_t  cls;
  logic       is_jz;
  logic       needs_two;
  logic       needs_one;
  logic       needs_room;
  logic       push_s, pop_s;
  logic       full, empty, ge2;

  assign op_lo      = bus.opcode[3:0];
  // Any set bit above the 4-bit opcode field makes the opcode illegal.
  assign upper_zero = ((bus.opcode >> 4) == '0);
  assign cls        = upper_zero ? classify(op_lo) : CLS_ILLEGAL;
  assign is_jz      = (op_lo == OP_JZ);

  assign needs_two  = (cls == CLS_BIN);
  assign needs_one  = (cls == CLS_NOT) || (cls == CLS_POP) ||
                      (cls == CLS_DUP) || ((cls == CLS_JUMP) && is_jz);
  assign needs_room = (cls == CLS_PUSH) || (cls == CLS_DUP);

  stack_depth_tracker #(.SP_W(SP_W)) u_depth (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .depth (bus.depth),
    .full  (full),
    .empty (empty),
    .ge2   (ge2)
  );

  // State and sticky trap code; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_FETCH;
      trap_code_q <= TRAP_NONE;
    end else begin
      state_q     <= state_d;
      trap_code_q <= trap_code_d;
    end
  end

  // Next-state logic: DECODE performs all stack checks before dispatch.
  always_comb begin
    state_d     = state_q;
    trap_code_d = trap_code_q;
    case (state_q)
      S_FETCH: begin
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (cls == CLS_ILLEGAL) begin
          state_d     = S_TRAP;
          trap_code_d = TRAP_ILLEGAL;
        end else if ((needs_two && !ge2) || (needs_one && empty)) begin
          state_d     = S_TRAP;
          trap_code_d = TRAP_UNDER;
        end else if (needs_room && full) begin
          state_d     = S_TRAP;
          trap_code_d = TRAP_OVER;
        end else begin
          case (cls)
            CLS_BIN, CLS_NOT, CLS_DUP: state_d = S_LOAD_A;
            CLS_PUSH:                  state_d = S_MEM_RD;
            CLS_POP:                   state_d = S_MEM_WR;
            CLS_JUMP:                  state_d = S_JUMP;
            default:                   state_d = S_HALT;
          endcase
        end
      end
      S_LOAD_A: begin
        if (cls == CLS_BIN)      state_d = S_LOAD_B;
        else if (cls == CLS_NOT) state_d = S_EXEC;
        else                     state_d = S_DUP1;
      end
      S_LOAD_B:   state_d = S_EXEC;
      S_EXEC:     state_d = S_FETCH;
      S_MEM_RD: begin
        if (bus.mem_ready) state_d = S_PUSH_MDR;
      end
      S_PUSH_MDR: state_d = S_FETCH;
      S_MEM_WR: begin
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_JUMP:     state_d = S_FETCH;
      S_DUP1:     state_d = S_DUP2;
      S_DUP2:     state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  // Output decode: Moore per state, with the memory-completion strobes
  // qualified by mem_ready.
  always_comb begin
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.ir_write  = 1'b0;
    bus.pc_inc    = 1'b0;
    bus.pc_write  = 1'b0;
    bus.addr_src  = 1'b0;
    bus.mdr_en    = 1'b0;
    bus.load_a    = 1'b0;
    bus.load_b    = 1'b0;
    bus.stack_src = SRC_MDR;
    push_s        = 1'b0;
    pop_s         = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.mem_read = 1'b1;
        bus.ir_write = bus.mem_ready;
        bus.pc_inc   = bus.mem_ready;
      end
      S_LOAD_A: begin
        pop_s      = 1'b1;
        bus.load_a = 1'b1;
      end
      S_LOAD_B: begin
        pop_s      = 1'b1;
        bus.load_b = 1'b1;
      end
      S_EXEC: begin
        push_s        = 1'b1;
        bus.stack_src = SRC_ALU;
      end
      S_MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.addr_src = 1'b1;
        bus.mdr_en   = bus.mem_ready;
      end
      S_PUSH_MDR: begin
        push_s        = 1'b1;
        bus.stack_src = SRC_MDR;
      end
      S_MEM_WR: begin
        bus.mem_write = 1'b1;
        bus.addr_src  = 1'b1;
        pop_s         = bus.mem_ready;
      end
      S_JUMP: begin
        bus.addr_src = 1'b1;
        bus.pc_write = is_jz ? bus.tos_zero : 1'b1;
      end
      S_DUP1, S_DUP2: begin
        push_s        = 1'b1;
        bus.stack_src = SRC_A;
      end
      default: begin
      end
    endcase
  end

  assign bus.push      = push_s;
  assign bus.pop       = pop_s;
  assign bus.alu_op    = op_lo[1:0];
  assign bus.halted    = (state_q == S_HALT);
  assign bus.trap      = (state_q == S_TRAP);
  assign bus.trap_code = trap_code_q;

endmodule

// File: tb/tb_stack_mc_controller.sv
// Randomized bench for stack_mc_controller. A per-instruction reference
// model predicts latency, strobe counts, push sources and the resulting
// stack depth or trap outcome; the bench plays memory with chosen wait
// states and compares the DUT against those predictions.
module tb_stack_mc_controller;

  localparam int OPW   = 4;
  localparam int SP_W  = 3;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stack_mc_controller_if #(.OPW(OPW), .SP_W(SP_W)) bus ();

  stack_mc_controller #(.OPW(OPW), .SP_W(SP_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vec_cnt = 0;
  int err_cnt = 0;
  int mdl_depth = 0;
  bit mdl_dead  = 1'b0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] ctl_bits();
    return {bus.mem_read, bus.mem_write, bus.ir_write, bus.pc_inc, bus.pc_write,
            bus.addr_src, bus.mdr_en, bus.load_a, bus.load_b, bus.push, bus.pop};
  endfunction

  // Outcome of issuing op at stack depth d:
  // 0 ok, 1 underflow, 2 overflow, 3 illegal, 4 halt.
  function automatic int fault_of(input int op, input int d);
    int need;
    if (!((op >= 0 && op <= 8) || op == 15)) return 3;
    if (op == 15) return 4;
    if (op <= 2) need = 2;
    else if (op == 3 || op == 5 || op == 7 || op == 8) need = 1;
    else need = 0;
    if (d < need) return 1;
    if ((op == 4 || op == 8) && d >= DEPTH) return 2;
    return 0;
  endfunction

  task automatic check_reset_state(input string tag);
    bus.mem_ready = 1'b0;
    #1;
    chk_eq({tag, "_ctl"}, 32'(ctl_bits()), 32'b100_0000_0000);
    chk_eq({tag, "_depth"}, 32'(bus.depth), 0);
    chk_eq({tag, "_flags"}, 32'({bus.halted, bus.trap, bus.trap_code}), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.mem_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    reset = 1'b0;
    mdl_depth = 0;
    mdl_dead  = 1'b0;
    check_reset_state("reset");
  endtask

  // Run one instruction with wf fetch wait states and wm memory wait states.
  task automatic run_instr(input int op, input int wf, input int wm, input bit tz);
    int f, lat, m0, dd;
    int e_rd, e_wr, e_as, e_pcw, e_mdr, e_la, e_lb, e_push, e_pop, e_sig;
    int n_rd, n_wr, n_as, n_pcw, n_mdr, n_la, n_lb, n_push, n_pop, sig;
    int n_ir, n_pci, ir_at, mdr_at, pop_at, alu_bad;
    logic mr;
    f  = fault_of(op, mdl_depth);
    m0 = wf + 2;
    dd = 0;
    e_rd = wf + 1; e_wr = 0; e_as = 0; e_pcw = 0; e_mdr = 0;
    e_la = 0; e_lb = 0; e_push = 0; e_pop = 0; e_sig = 0;
    lat = 2;
    if (f == 0) begin
      case (op)
        0, 1, 2: begin lat = 5; e_la = 1; e_lb = 1; e_pop = 2; e_push = 1; e_sig = 2; dd = -1; end
        3:       begin lat = 4; e_la = 1; e_pop = 1; e_push = 1; e_sig = 2; end
        4:       begin lat = 4 + wm; e_rd += wm + 1; e_as = wm + 1; e_mdr = 1; e_push = 1; e_sig = 1; dd = 1; end
        5:       begin lat = 3 + wm; e_wr = wm + 1; e_as = wm + 1; e_pop = 1; dd = -1; end
        6:       begin lat = 3; e_as = 1; e_pcw = 1; end
        7:       begin lat = 3; e_as = 1; e_pcw = int'(tz); end
        default: begin lat = 5; e_la = 1; e_pop = 1; e_push = 2; e_sig = 15; dd = 1; end
      endcase
    end
    lat += wf;
    n_rd = 0; n_wr = 0; n_as = 0; n_pcw = 0; n_mdr = 0; n_la = 0; n_lb = 0;
    n_push = 0; n_pop = 0; sig = 0; n_ir = 0; n_pci = 0;
    ir_at = -1; mdr_at = -1; pop_at = -1; alu_bad = 0;
    bus.opcode = op[OPW-1:0];
    for (int c = 0; c < lat; c++) begin
      @(negedge clk);
      if (c < wf) mr = 1'b0;
      else if (c == wf) mr = 1'b1;
      else if (f == 0 && (op == 4 || op == 5) && c >= m0) mr = (c == m0 + wm);
      else mr = 1'($urandom_range(0, 1));
      bus.mem_ready = mr;
      bus.tos_zero  = (op == 7) ? tz : 1'($urandom_range(0, 1));
      #1;
      n_rd   += int'(bus.mem_read);
      n_wr   += int'(bus.mem_write);
      n_as   += int'(bus.addr_src);
      n_pcw  += int'(bus.pc_write);
      n_mdr  += int'(bus.mdr_en);
      n_la   += int'(bus.load_a);
      n_lb   += int'(bus.load_b);
      n_pop  += int'(bus.pop);
      n_ir   += int'(bus.ir_write);
      n_pci  += int'(bus.pc_inc);
      if (bus.ir_write) ir_at = c;
      if (bus.mdr_en) mdr_at = c;
      if (bus.pop && op == 5) pop_at = c;
      if (bus.push) begin
        n_push++;
        sig = sig * 4 + int'(bus.stack_src) + 1;
      end
      if (bus.alu_op !== op[1:0]) alu_bad++;
    end
    chk_eq("ir_write_cnt", n_ir, 1);
    chk_eq("ir_write_cycle", ir_at, wf);
    chk_eq("pc_inc_cnt", n_pci, 1);
    chk_eq("mem_read_cnt", n_rd, e_rd);
    chk_eq("mem_write_cnt", n_wr, e_wr);
    chk_eq("addr_src_cnt", n_as, e_as);
    chk_eq("pc_write_cnt", n_pcw, e_pcw);
    chk_eq("mdr_en_cnt", n_mdr, e_mdr);
    chk_eq("load_a_cnt", n_la, e_la);
    chk_eq("load_b_cnt", n_lb, e_lb);
    chk_eq("push_cnt", n_push, e_push);
    chk_eq("pop_cnt", n_pop, e_pop);
    chk_eq("push_src_seq", sig, e_sig);
    chk_eq("alu_op", alu_bad, 0);
    if (f == 0 && op == 4) chk_eq("mdr_en_cycle", mdr_at, m0 + wm);
    if (f == 0 && op == 5) chk_eq("mem_wr_pop_cycle", pop_at, m0 + wm);
    if (f == 0) begin
      mdl_depth += dd;
      @(negedge clk);
      bus.mem_ready = 1'b0;
      #1;
      chk_eq("boundary_fetch", 32'(ctl_bits()), 32'b100_0000_0000);
      chk_eq("depth", 32'(bus.depth), mdl_depth);
      chk_eq("not_stopped", 32'({bus.halted, bus.trap}), 0);
    end else begin
      mdl_dead = 1'b1;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        bus.mem_ready = 1'($urandom_range(0, 1));
        bus.tos_zero  = 1'($urandom_range(0, 1));
        #1;
        chk_eq("terminal_strobes", 32'(ctl_bits()), 0);
      end
      chk_eq("halted", 32'(bus.halted), (f == 4) ? 1 : 0);
      chk_eq("trap", 32'(bus.trap), (f == 4) ? 0 : 1);
      chk_eq("trap_code", 32'(bus.trap_code), (f == 4) ? 0 : f);
      chk_eq("depth_after_stop", 32'(bus.depth), mdl_depth);
    end
  endtask

  function automatic int pick_op();
    int r;
    int legal[8] = '{0, 1, 2, 3, 5, 6, 7, 8};
    r = $urandom_range(0, 99);
    if (r < 3) return $urandom_range(0, 15);
    if (r < 40) return 4;
    return legal[$urandom_range(0, 7)];
  endfunction

  initial begin
    reset = 1'b1;
    bus.opcode = '0;
    bus.tos_zero = 1'b0;
    bus.mem_ready = 1'b0;
    #12;
    chk_eq("async_reset_depth", 32'(bus.depth), 0);
    do_reset();

    // PUSH, PUSH, ADD with no wait states, then PUSH with 3 memory waits.
    run_instr(4, 0, 0, 1'b0);
    run_instr(4, 0, 0, 1'b0);
    run_instr(0, 0, 0, 1'b0);
    run_instr(4, 0, 3, 1'b0);
    run_instr(7, 0, 0, 1'b0);
    run_instr(7, 1, 0, 1'b1);
    run_instr(6, 0, 0, 1'b0);
    run_instr(5, 2, 2, 1'b0);

    // Underflow: ADD at depth 1.
    do_reset();
    run_instr(4, 0, 0, 1'b0);
    run_instr(0, 0, 0, 1'b0);

    // Overflow: PUSH at full depth.
    do_reset();
    for (int i = 0; i < DEPTH; i++) run_instr(4, 0, 0, 1'b0);
    run_instr(4, 0, 0, 1'b0);

    // Illegal opcode at depth 0 wins over underflow and stays sticky.
    do_reset();
    run_instr(10, 0, 0, 1'b0);
    do_reset();

    // DUP at depth 1, then HALT.
    run_instr(4, 0, 0, 1'b0);
    run_instr(8, 0, 0, 1'b0);
    run_instr(15, 0, 0, 1'b0);

    // Reset in the middle of a POP waiting on memory.
    do_reset();
    run_instr(4, 0, 0, 1'b0);
    run_instr(4, 0, 0, 1'b0);
    bus.opcode = 4'h5;
    @(negedge clk); bus.mem_ready = 1'b1;
    @(negedge clk); bus.mem_ready = 1'b0;
    @(negedge clk); bus.mem_ready = 1'b0;
    #1;
    chk_eq("mid_wr_strobe", 32'(bus.mem_write), 1);
    reset = 1'b1;
    #1;
    chk_eq("mid_reset_ctl", 32'(ctl_bits()), 32'b100_0000_0000);
    chk_eq("mid_reset_depth", 32'(bus.depth), 0);
    @(negedge clk);
    bus.mem_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mdl_depth = 0;
    mdl_dead  = 1'b0;
    check_reset_state("after_mid_reset");

    // Random episodes with random wait states.
    for (int e = 0; e < 8; e++) begin
      do_reset();
      for (int n = 0; n < 25 && !mdl_dead; n++) begin
        run_instr(pick_op(), $urandom_range(0, 2), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/stack_mc_controller.md
# stack_mc_controller

Parametrised multicycle control unit for the stack-machine datapath: sequences fetch/decode/execute for a widened opcode set and drives memory, IR, PC, A/B operand registers, ALU op and stack push/pop. Compared with the first-generation controller, it adds:
- a memory wait-state handshake;
- an internal stack-depth counter with underflow/overflow/illegal-opcode traps;
- DUP and HALT instructions.

It sits between the instruction register/opcode field and the datapath enables.

## Interface
Parameters:
- OPW, 4: opcode width (≥4).
- SP_W, 3: log2 of stack depth; DEPTH = 2**SP_W.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- opcode  in  OPW  opcode field of IR (stable from DECODE through end of instruction).
- tos_zero  in  1  top-of-stack == 0.
- mem_ready  in  1  memory access completes this cycle.
- mem_read, mem_write  out  1  memory strobes.
- ir_write, pc_inc, pc_write  out  1  IR load, PC+1, PC load from IR address.
- addr_src  out  1  0=PC, 1=IR address.
- mdr_en  out  1  capture memory data into MDR.
- load_a, load_b  out  1  operand register loads (from stack top).
- alu_op  out  2  ALU function (= opcode[1:0]).
- push, pop  out  1  stack strobes.
- stack_src  out  2  push source: 0=MDR, 1=ALU, 2=A register.
- depth  out  SP_W+1  current stack occupancy, 0..DEPTH.
- halted  out  1  sticky, HALT executed.
- trap  out  1  sticky, fault detected.
- trap_code  out  2  01 underflow, 10 overflow, 11 illegal opcode.

## Operation
Opcodes (upper OPW-4 bits must be zero, else illegal):
- 0000 ADD, 0001 SUB, 0010 AND (pop 2, push 1).
- 0011 NOT (pop 1, push 1).
- 0100 PUSH addr, 0101 POP addr.
- 0110 JMP, 0111 JZ (JZ does not pop).
- 1000 DUP (pop 1, push 2).
- 1111 HALT.
- All others illegal.

States and transitions:
- FETCH: mem_read=1, addr_src=0. Holds until mem_ready. On the ready cycle, ir_write=1 and pc_inc=1, then → DECODE.
- DECODE: checks the stack requirement and dispatches.
  - Binary op needs depth≥2; NOT/POP/JZ/DUP need depth≥1; otherwise → TRAP, code 01.
  - PUSH needs depth<DEPTH; DUP needs depth<DEPTH; otherwise → TRAP, code 10.
  - Illegal opcode → TRAP, code 11. The illegal check takes priority over depth checks.
  - Dispatch: ALU/DUP → LOAD_A; PUSH → MEM_RD; POP → MEM_WR; JMP/JZ → JUMP; HALT → HALT.
- LOAD_A: pop=1, load_a=1.
  - Binary op → LOAD_B.
  - NOT → EXEC.
  - DUP → DUP1.
- LOAD_B: pop=1, load_b=1 → EXEC.
- EXEC: push=1, stack_src=1, alu_op valid → FETCH.
- MEM_RD: mem_read=1, addr_src=1. Holds until mem_ready; on the ready cycle mdr_en=1 → PUSH_MDR.
- PUSH_MDR: push=1, stack_src=0 → FETCH.
- MEM_WR: mem_write=1, addr_src=1. Holds until mem_ready; pop=1 only on the ready cycle → FETCH.
- JUMP: pc_write = (JMP) ? 1 : tos_zero; addr_src=1 → FETCH.
- DUP1 and DUP2: each push=1, stack_src=2. DUP1 → DUP2 → FETCH.
- HALT: halted=1. TRAP: trap=1 with trap_code held. Both are terminal until reset; no strobes asserted.

Depth counter and ALU op:
- depth increments on push and decrements on pop; the two are never simultaneous.
- DECODE guarantees the counter never wraps. An RTL assertion fires if push occurs at depth==DEPTH or pop at depth==0.
- alu_op = opcode[1:0] in all states.

## Timing
- Reset:
  - state = FETCH, depth = 0, trap_code = 00.
  - halted = trap = 0.
  - mem_read = 1, addr_src = 0; all other outputs 0.
- Strobe types:
  - ir_write, pc_inc, mdr_en and MEM_WR pop/advance are Mealy, qualified by mem_ready.
  - All other outputs are Moore.
- Instruction latency with zero wait states (mem_ready tied 1):
  - ADD/SUB/AND 5 cycles; NOT 4; PUSH 4; POP 3; JMP/JZ 3; DUP 5.
  - Each memory wait cycle adds 1.
- Reset asserted mid-instruction aborts immediately. No partial push/pop completes after the reset edge.
- The trap check happens in DECODE before any stack strobe, so a trapped instruction leaves depth unchanged.

## Structure
- A shared package holds:
  - the opcode enum (OP_ADD … OP_HALT);
  - the state enum;
  - the stack_src encodings (SRC_MDR/SRC_ALU/SRC_A);
  - the trap_code constants.
- One natural sub-module: stack_depth_tracker (SP_W parameter; push/pop in, depth out, plus the full/empty/≥2 flags used by DECODE).

## Test plan
- Reset, then PUSH, PUSH, ADD with mem_ready=1:
  - required: depth goes 0→1→2→1;
  - exactly 4+4+5 cycles;
  - EXEC asserts push with stack_src=1 and alu_op=00.
- PUSH with mem_ready low for 3 cycles in MEM_RD:
  - mem_read/addr_src=1 held for 4 cycles;
  - mdr_en pulses once, on the ready cycle;
  - total 7 cycles.
- Underflow and overflow:
  - ADD at depth=1 → TRAP code 01, depth stays 1, no pop issued.
  - PUSH at depth=DEPTH (8) → TRAP code 10.
- Illegal opcode 1010 at depth 0 → trap_code 11 (priority over underflow), sticky until reset.
- JZ with tos_zero=0 → pc_write=0. JZ with tos_zero=1 → pc_write=1 for one cycle. depth is unchanged in both cases.
- DUP at depth=1 → two pushes with stack_src=2, depth=2. Then HALT → halted=1 and no further mem_read.
